// File: rtl/sd_adc_pkg.sv
// Shared types and helpers for the sigma-delta ADC front end.
package sd_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN
  } sd_state_e;

  localparam int OSR_LOG2_DEF = 10;
  localparam int DATA_W_DEF   = 8;
  localparam int WIN_MAX      = (1 << OSR_LOG2_DEF) - 1;

  // A window total of exactly 2^osr_log2 would wrap the top-bit slice, so clamp it to all-ones.
  function automatic logic [31:0] sd_scale(input logic [31:0] total,
                                           input int          osr_log2,
                                           input int          data_w);
    logic [31:0] mask;
    mask = (32'd1 << data_w) - 32'd1;
    if (total == (32'd1 << osr_log2)) return mask;
    return (total >> (osr_log2 - data_w)) & mask;
  endfunction

endpackage

// File: rtl/sd_adc_sync.sv
// Comparator synchroniser: SYNC_STAGES flop chain, synchronous active-high reset.
module sd_adc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_chain <= '0;
    else         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/sd_adc_frontend.sv
// Per-axis first-order sigma-delta front end: sync, feedback, window count, valid/ready sample.
// Optional two-window averaging of the output is enabled by defining SD_ADC_AVG_EN.
module sd_adc_frontend
  import sd_adc_pkg::*;
#(
  parameter int OSR_LOG2    = OSR_LOG2_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              comp_async_i,
  output logic              dac_fb_o,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              overrun_o
);

  sd_state_e           r_state, w_state_next;
  logic                w_comp_sync;
  logic [OSR_LOG2-1:0] r_win;
  logic [OSR_LOG2:0]   r_ones, w_total;
  logic                w_active, w_tc, w_sample_tc, w_xfer;
  logic [DATA_W-1:0]   w_scaled, w_out, r_sample;
  logic                r_valid, r_ovr, r_dac;

  sd_adc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_async (comp_async_i),
    .o_sync  (w_comp_sync)
  );

  // Dropping enable takes effect on the same cycle: nothing is accumulated or emitted.
  assign w_active    = (r_state != IDLE) && enable_i;
  assign w_tc        = w_active && (r_win == '1);
  assign w_sample_tc = w_tc && (r_state == RUN);
  assign w_total     = r_ones + (OSR_LOG2+1)'(w_comp_sync);
  assign w_scaled    = DATA_W'(sd_scale(32'(w_total), OSR_LOG2, DATA_W));
  assign w_xfer      = r_valid && sample_ready_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_state_next = SETTLE;
      SETTLE:  if (!enable_i) w_state_next = IDLE;
               else if (w_tc) w_state_next = RUN;
      RUN:     if (!enable_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !w_active || w_tc) begin
      r_win  <= '0;
      r_ones <= '0;
    end else begin
      r_win  <= r_win + 1'b1;
      r_ones <= w_total;
    end
  end

`ifdef SD_ADC_AVG_EN
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_vld;
  logic [DATA_W:0]   w_sum;

  assign w_sum = {1'b0, r_prev} + {1'b0, w_scaled} + (DATA_W+1)'(1);
  assign w_out = r_prev_vld ? DATA_W'(w_sum >> 1) : w_scaled;

  // History restarts at the SETTLE->RUN boundary so the first RUN sample is unaveraged.
  always_ff @(posedge clk_i) begin
    if (reset_i || (w_tc && r_state == SETTLE)) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_sample_tc) begin
      r_prev     <= w_scaled;
      r_prev_vld <= 1'b1;
    end
  end
`else
  assign w_out = w_scaled;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
      r_dac    <= 1'b0;
    end else begin
      r_dac <= w_active & w_comp_sync;
      r_ovr <= 1'b0;
      if (!w_active) begin
        r_valid <= 1'b0;
      end else if (w_sample_tc) begin
        r_sample <= w_out;
        r_valid  <= 1'b1;
        r_ovr    <= r_valid & ~sample_ready_i;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dac_fb_o       = r_dac;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign overrun_o      = r_ovr;

endmodule

// File: tb/tb_sd_adc_frontend.sv
// Self-checking bench for sd_adc_frontend against a window-level reference model.
module tb_sd_adc_frontend;

  localparam int OSR_LOG2    = 8;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int WIN         = 1 << OSR_LOG2;
`ifdef SD_ADC_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              enable_i = 1'b0;
  logic              comp_async_i = 1'b0;
  logic              sample_ready_i = 1'b0;
  logic              dac_fb_o, sample_valid_o, overrun_o;
  logic [DATA_W-1:0] sample_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  sd_adc_frontend #(
    .OSR_LOG2    (OSR_LOG2),
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .comp_async_i   (comp_async_i),
    .dac_fb_o       (dac_fb_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .overrun_o      (overrun_o)
  );

  // Reference model: comparator delay line, list of synced bits in the current window.
  bit m_dly[$];
  bit m_bits[$];
  bit m_active;
  int m_windows;
  bit m_have_prev;
  int m_prev;
  int e_sample, e_valid, e_ovr, e_dac;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int scale(input int total);
    if (total == WIN) return (1 << DATA_W) - 1;
    return (total >> (OSR_LOG2 - DATA_W)) % (1 << DATA_W);
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit comp, input bit rdy);
    bit cs;
    int total, cur;
    if (rst) begin
      m_dly.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_dly.push_back(1'b0);
      m_bits.delete();
      m_active = 0; m_windows = 0; m_have_prev = 0; m_prev = 0;
      e_sample = 0; e_valid = 0; e_ovr = 0; e_dac = 0;
      return;
    end
    cs = m_dly.pop_front();
    m_dly.push_back(comp);
    e_ovr = 0;
    if (!m_active || !en) begin
      e_dac = 0; e_valid = 0;
      m_bits.delete();
      m_windows = 0;
      m_active = !m_active && en;
      return;
    end
    e_dac = cs;
    m_bits.push_back(cs);
    if (m_bits.size() == WIN) begin
      total = 0;
      foreach (m_bits[i]) total += int'(m_bits[i]);
      m_bits.delete();
      m_windows++;
      if (m_windows == 1) begin
        m_have_prev = 0;
      end else begin
        cur = scale(total);
        e_ovr = (e_valid != 0 && !rdy) ? 1 : 0;
        e_sample = (AVG && m_have_prev) ? (m_prev + cur + 1) / 2 : cur;
        m_prev = cur; m_have_prev = 1; e_valid = 1;
      end
    end else if (e_valid != 0 && rdy) begin
      e_valid = 0;
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit comp, input bit rdy);
    reset_i = rst; enable_i = en; comp_async_i = comp; sample_ready_i = rdy;
    @(posedge clk_i);
    model_step(rst, en, comp, rdy);
    @(negedge clk_i);
    chk("sample", 32'(sample_o), e_sample);
    chk("valid", 32'(sample_valid_o), e_valid);
    chk("overrun", 32'(overrun_o), e_ovr);
    chk("dac_fb", 32'(dac_fb_o), e_dac);
  endtask

  // Enable from IDLE and count cycles until the first valid sample appears.
  task automatic measure_latency(input string tag, input int dens);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    while (!seen && n < 700) begin
      cyc(0, 1, $urandom_range(0, 99) < dens, 0);
      n++;
      seen = sample_valid_o;
    end
    chk(tag, n, 2 * WIN + 1);
  endtask

  int  cnt, dens, guard;
  logic [DATA_W-1:0] last, first;
  bit  en_r, rst_r;

  initial begin
    // Reset state
    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_sample", 32'(sample_o), 0);
    chk("rst_valid", 32'(sample_valid_o), 0);

    // comp held 1: SETTLE then first sample saturated
    repeat (4) cyc(0, 0, 1, 0);
    measure_latency("s1_latency", 100);
    chk("s1_sample", 32'(sample_o), 32'hFF);
    chk("s1_dac", 32'(dac_fb_o), 1);
    cyc(0, 1, 1, 1);
    chk("s1_consumed", 32'(sample_valid_o), 0);

    // toggling comparator settles to mid-scale
    last = '0;
    for (int i = 0; i < 4 * WIN; i++) begin
      cyc(0, 1, i[0], 1);
      if (sample_valid_o) last = sample_o;
    end
    chk("s3_steady", 32'(last), 32'h80);

    // comp held 0
    for (int i = 0; i < 3 * WIN; i++) begin
      cyc(0, 1, 0, 1);
      if (sample_valid_o) last = sample_o;
    end
    chk("s2_zero", 32'(last), 0);
    chk("s2_dac", 32'(dac_fb_o), 0);

    // randomized density, ready, rare enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      if (i % WIN == 0) dens = $urandom_range(0, 100);
      en_r  = ($urandom_range(0, 999) != 0);
      rst_r = ($urandom_range(0, 2999) == 0);
      cyc(rst_r, en_r, $urandom_range(0, 99) < dens, $urandom_range(0, 3) != 0);
    end

    // overrun: ready low across two RUN windows
    cyc(1, 0, 0, 0);
    guard = 0;
    while (!(m_windows >= 1 && m_bits.size() == WIN - 1) && guard < 1000) begin
      cyc(0, 1, 1, 1); guard++;
    end
    chk("s4_reach", 32'(guard < 1000), 1);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1);
    chk("s4_idle_valid", 32'(sample_valid_o), 0);
    cnt = 0; first = '0;
    for (int i = 0; i < 2 * WIN; i++) begin
      cyc(0, 1, (sample_valid_o ? 1'b0 : 1'b1), 0);
      if (overrun_o) cnt++;
      if (sample_valid_o && cnt == 0) first = sample_o;
    end
    chk("s4_ovr_pulses", cnt, 1);
    chk("s4_valid", 32'(sample_valid_o), 1);
    chk("s4_newest", 32'(sample_o != first), 1);

    // ready asserted exactly on the landing cycle
    guard = 0;
    while (m_bits.size() != WIN - 1 && guard < 300) begin
      cyc(0, 1, $urandom_range(0, 1), 0); guard++;
    end
    chk("s5_pre_valid", 32'(sample_valid_o), 1);
    cyc(0, 1, $urandom_range(0, 1), 1);
    chk("s5_valid", 32'(sample_valid_o), 1);
    chk("s5_ovr", 32'(overrun_o), 0);

    // reset at window cycle 100
    repeat (100) cyc(0, 1, $urandom_range(0, 1), 0);
    chk("s6_pos", m_bits.size(), 100);
    cyc(1, 1, 1, 0);
    chk("s6_rst_sample", 32'(sample_o), 0);
    chk("s6_rst_valid", 32'(sample_valid_o), 0);
    chk("s6_rst_dac", 32'(dac_fb_o), 0);
    measure_latency("s6_rst_relatency", 60);

    // enable drop at window cycle 100 keeps sample_o
    guard = 0;
    while (m_bits.size() != 100 && guard < 300) begin
      cyc(0, 1, 1, 0); guard++;
    end
    chk("s6_pre_valid", 32'(sample_valid_o), 1);
    last = sample_o;
    cyc(0, 0, 1, 0);
    chk("s6_en_valid", 32'(sample_valid_o), 0);
    chk("s6_en_dac", 32'(dac_fb_o), 0);
    chk("s6_en_ovr", 32'(overrun_o), 0);
    chk("s6_en_hold", 32'(sample_o), e_sample);
    chk("s6_en_keep", 32'(sample_o == last), 1);
    repeat (3) cyc(0, 0, 1, 0);
    measure_latency("s6_en_relatency", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
